// File: rtl/data_c_pipe_sync_tap_if.sv
// Stream bundle for data_c_pipe_sync_tap: valid/ready handshake with data and sideband.
// master drives valid/data/side and samples ready; slave does the reverse.
interface data_c_pipe_sync_tap_if #(
   parameter int DSIZE = 32,
   parameter int SSIZE = 8
) ();
   logic             valid;
   logic             ready;
   logic [DSIZE-1:0] data;
   logic [SSIZE-1:0] side;

   modport master (
      output valid,
      output data,
      output side,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  side,
      output ready
   );
endinterface

// File: rtl/data_c_pipe_sync_tap.sv
// LAT-stage valid/ready pipe carrying a per-beat sideband word, with every
// stage's occupancy and sideband exposed on tap outputs.
// Ports: clock, rst_n (async, active low), flush (sync clear),
//   in_bus (slave: valid/data/side in, ready out), out_bus (master),
//   tap_valid[LAT], tap_side[LAT], count = popcount of occupied stages.
// Optional: define DATA_C_PIPE_TAP_STALL_CNT_EN to add stall_cnt[15:0],
//   a saturating count of out_valid & !out_ready cycles, cleared by flush.
module data_c_pipe_sync_tap #(
   parameter int LAT   = 4,
   parameter int DSIZE = 32,
   parameter int SSIZE = 8,
   localparam int CW   = $clog2(LAT + 1)
) (
   input  logic                    clock,
   input  logic                    rst_n,
   input  logic                    flush,
   data_c_pipe_sync_tap_if.slave   in_bus,
   data_c_pipe_sync_tap_if.master  out_bus,
   output logic [LAT-1:0]          tap_valid,
   output logic [SSIZE-1:0]        tap_side [LAT],
`ifdef DATA_C_PIPE_TAP_STALL_CNT_EN
   output logic [15:0]             stall_cnt,
`endif
   output logic [CW-1:0]           count
);

   logic [LAT-1:0]   v;
   logic [DSIZE-1:0] d  [LAT];
   logic [SSIZE-1:0] s  [LAT];

   logic [LAT-1:0]   rdy;
   logic [LAT-1:0]   uv;
   logic [DSIZE-1:0] ud [LAT];
   logic [SSIZE-1:0] us [LAT];

   // Ready ripples back from the sink; an empty stage always accepts.
   always_comb begin
      logic r;
      r = out_bus.ready;
      for (int k = LAT - 1; k >= 0; k--) begin
         r      = !v[k] | r;
         rdy[k] = r;
      end
   end

   always_comb begin
      uv[0] = in_bus.valid;
      ud[0] = in_bus.data;
      us[0] = in_bus.side;
      for (int k = 1; k < LAT; k++) begin
         uv[k] = v[k-1];
         ud[k] = d[k-1];
         us[k] = s[k-1];
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
         for (int k = 0; k < LAT; k++) begin
            d[k] <= '0;
            s[k] <= '0;
         end
      end else if (flush) begin
         v <= '0;
      end else begin
         for (int k = 0; k < LAT; k++) begin
            if (rdy[k]) begin
               v[k] <= uv[k];
               if (uv[k]) begin
                  d[k] <= ud[k];
                  s[k] <= us[k];
               end
            end
         end
      end
   end

   // Recomputed from the valid bits every cycle so it can never drift.
   always_comb begin
      count = '0;
      for (int k = 0; k < LAT; k++)
         count = count + CW'(v[k]);
   end

   always_comb begin
      tap_valid = v;
      for (int k = 0; k < LAT; k++)
         tap_side[k] = s[k];
   end

   assign in_bus.ready  = rdy[0];
   assign out_bus.valid = v[LAT-1];
   assign out_bus.data  = d[LAT-1];
   assign out_bus.side  = s[LAT-1];

`ifdef DATA_C_PIPE_TAP_STALL_CNT_EN
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (flush)
         stall_cnt <= '0;
      else if (v[LAT-1] && !out_bus.ready && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end
`endif

endmodule
